// File: rtl/eth_rx_fcs_check_if.sv
// eth_rx_fcs_check_if: PHY-side RX byte stream plus checked payload/status outputs.
// Latency: none. This file only groups signals.
// Backpressure: none. The PHY stream cannot stall, and the sink takes every m_valid byte.
interface eth_rx_fcs_check_if;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rx_data;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_sof;
  logic        done;
  logic        ok;
  logic [2:0]  status;
  logic [15:0] frame_len;
  logic [31:0] cnt_good;
  logic [31:0] cnt_bad;

  // PHY/driver side: sources the RX stream and observes the checker outputs
  modport master (
    output rx_dv, rx_er, rx_data,
    input  m_valid, m_data, m_sof, done, ok, status, frame_len, cnt_good, cnt_bad
  );

  // checker side
  modport slave (
    input  rx_dv, rx_er, rx_data,
    output m_valid, m_data, m_sof, done, ok, status, frame_len, cnt_good, cnt_bad
  );
endinterface

// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: finds preamble/SFD, forwards DA..payload with the 4-byte FCS stripped, checks CRC-32.
// Latency: payload byte N is presented the cycle after byte N+4 arrives; done follows the rx_dv fall by 1 cycle.
// Backpressure: none. The PHY cannot be stalled, so every m_valid byte must be taken.
module eth_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int MIN_PRE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  eth_rx_fcs_check_if.slave bus
);

  localparam int              PW        = $clog2(MIN_PRE + 1) + 1;
  localparam logic [PW-1:0]   PRE_REQ   = PW'(MIN_PRE);
  localparam logic [15:0]     LEN_GIANT = 16'(MAX_LEN + 1);
  localparam logic [31:0]     CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0]     CRC_POLY  = 32'hEDB8_8320;  // 04C11DB7 bit-reversed

  localparam logic [2:0] ST_OK     = 3'd0;
  localparam logic [2:0] ST_FCS    = 3'd1;
  localparam logic [2:0] ST_RUNT   = 3'd2;
  localparam logic [2:0] ST_GIANT  = 3'd3;
  localparam logic [2:0] ST_RXER   = 3'd4;
  localparam logic [2:0] ST_NO_SFD = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_BODY,
    S_DROP
  } state_t;

  // One byte of the reflected CRC-32, LSB of the byte first as on the wire.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // frame tracking state
  state_t          state_q;
  logic [PW-1:0]   pre_cnt_q;
  logic [3:0][7:0] dly_q;         // [0] oldest byte, [3] newest
  logic [15:0]     len_q;
  logic [31:0]     crc_q;
  logic            err_q;
  logic            sof_pend_q;
  logic [2:0]      drop_status_q;

  // registered outputs
  logic            m_valid_q;
  logic [7:0]      m_data_q;
  logic            m_sof_q;
  logic            done_q;
  logic            ok_q;
  logic [2:0]      status_q;
  logic [15:0]     frame_len_q;
  logic [31:0]     cnt_good_q;
  logic [31:0]     cnt_bad_q;

  // combinational helpers
  logic [15:0]     len_d;
  logic [31:0]     crc_d;
  logic            emit;
  logic            fcs_ok;
  logic [2:0]      end_status;
  logic            fin_vld;
  logic [2:0]      fin_status;

  // Per-byte datapath terms and the end-of-frame verdict.
  always_comb begin
    len_d = len_q + 16'd1;
    // Once four bytes are buffered, each new byte pushes the oldest one out for forwarding.
    emit  = (state_q == S_BODY) && bus.rx_dv && (len_q >= 16'd4);
    crc_d = crc32_byte(crc_q, dly_q[0]);
    // When the frame ends, the delay line holds the received FCS, and it must equal the
    // complemented register, LSB byte first.
    fcs_ok = (dly_q == ~crc_q);

    end_status = ST_OK;
    if (err_q) begin
      end_status = ST_RXER;
    end else if (int'(len_q) < MIN_LEN) begin
      end_status = ST_RUNT;
    end else if (!fcs_ok) begin
      end_status = ST_FCS;
    end

    fin_vld    = !bus.rx_dv && ((state_q == S_BODY) || (state_q == S_DROP));
    fin_status = (state_q == S_BODY) ? end_status : drop_status_q;
  end

  // Frame FSM, delay line, CRC, payload outputs, end-of-frame status and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pre_cnt_q     <= '0;
      dly_q         <= '0;
      len_q         <= '0;
      crc_q         <= CRC_INIT;
      err_q         <= 1'b0;
      sof_pend_q    <= 1'b0;
      drop_status_q <= ST_OK;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_sof_q       <= 1'b0;
      done_q        <= 1'b0;
      ok_q          <= 1'b0;
      status_q      <= ST_OK;
      frame_len_q   <= '0;
      cnt_good_q    <= '0;
      cnt_bad_q     <= '0;
    end else begin
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.rx_dv) begin
            if (bus.rx_data == 8'h55) begin
              state_q   <= S_PRE;
              pre_cnt_q <= PW'(1);
            end else begin
              state_q       <= S_DROP;
              drop_status_q <= ST_NO_SFD;
              len_q         <= '0;
            end
          end
        end

        S_PRE: begin
          if (!bus.rx_dv) begin
            // Preamble that never reached an SFD is not a frame. No status is reported.
            state_q <= S_IDLE;
          end else if (bus.rx_data == 8'h55) begin
            if (pre_cnt_q < PRE_REQ) begin
              pre_cnt_q <= pre_cnt_q + PW'(1);
            end
          end else if ((bus.rx_data == 8'hD5) && (pre_cnt_q >= PRE_REQ)) begin
            state_q    <= S_BODY;
            crc_q      <= CRC_INIT;
            dly_q      <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            sof_pend_q <= 1'b1;
          end else begin
            state_q       <= S_DROP;
            drop_status_q <= ST_NO_SFD;
            len_q         <= '0;
          end
        end

        S_BODY: begin
          if (!bus.rx_dv) begin
            state_q <= S_IDLE;
          end else begin
            dly_q <= {bus.rx_data, dly_q[3:1]};
            len_q <= len_d;
            if (bus.rx_er) begin
              err_q <= 1'b1;
            end
            if (emit) begin
              m_valid_q  <= 1'b1;
              m_data_q   <= dly_q[0];
              m_sof_q    <= sof_pend_q;
              sof_pend_q <= 1'b0;
              crc_q      <= crc_d;
            end
            // The byte that crosses the limit is still forwarded. Nothing after it is.
            if (len_d == LEN_GIANT) begin
              state_q       <= S_DROP;
              drop_status_q <= ST_GIANT;
            end
          end
        end

        S_DROP: begin
          if (!bus.rx_dv) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (fin_vld) begin
        done_q      <= 1'b1;
        ok_q        <= (fin_status == ST_OK);
        status_q    <= fin_status;
        frame_len_q <= len_q;
        if (fin_status == ST_OK) begin
          cnt_good_q <= cnt_good_q + 32'd1;
        end else if (fin_status != ST_NO_SFD) begin
          cnt_bad_q <= cnt_bad_q + 32'd1;
        end
      end
    end
  end

  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_sof     = m_sof_q;
  assign bus.done      = done_q;
  assign bus.ok        = ok_q;
  assign bus.status    = status_q;
  assign bus.frame_len = frame_len_q;
  assign bus.cnt_good  = cnt_good_q;
  assign bus.cnt_bad   = cnt_bad_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb_eth_rx_fcs_check: directed frame vectors against three checker configurations.
// Latency: the bench samples on the falling edge and drives 1 time unit after the rising edge.
// Backpressure: none. The monitors take every byte.
module tb_eth_rx_fcs_check;

  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // u0: MIN_LEN=0, u1: defaults, u2: MAX_LEN=100
  eth_rx_fcs_check_if if0 ();
  eth_rx_fcs_check_if if1 ();
  eth_rx_fcs_check_if if2 ();

  eth_rx_fcs_check #(.MIN_LEN(0))   u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  eth_rx_fcs_check                  u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  eth_rx_fcs_check #(.MAX_LEN(100)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [2:0] rx_dv;
  logic [2:0] rx_er;
  logic [7:0] rx_data [3];

  assign if0.rx_dv = rx_dv[0];  assign if0.rx_er = rx_er[0];  assign if0.rx_data = rx_data[0];
  assign if1.rx_dv = rx_dv[1];  assign if1.rx_er = rx_er[1];  assign if1.rx_data = rx_data[1];
  assign if2.rx_dv = rx_dv[2];  assign if2.rx_er = rx_er[2];  assign if2.rx_data = rx_data[2];

  logic [2:0]  mv, ms, dn, okv;
  logic [2:0]  st [3];
  logic [15:0] fl [3];
  logic [31:0] cg [3];
  logic [31:0] cb [3];

  assign mv  = {if2.m_valid, if1.m_valid, if0.m_valid};
  assign ms  = {if2.m_sof, if1.m_sof, if0.m_sof};
  assign dn  = {if2.done, if1.done, if0.done};
  assign okv = {if2.ok, if1.ok, if0.ok};
  assign st[0] = if0.status;    assign st[1] = if1.status;    assign st[2] = if2.status;
  assign fl[0] = if0.frame_len; assign fl[1] = if1.frame_len; assign fl[2] = if2.frame_len;
  assign cg[0] = if0.cnt_good;  assign cg[1] = if1.cnt_good;  assign cg[2] = if2.cnt_good;
  assign cb[0] = if0.cnt_bad;   assign cb[1] = if1.cnt_bad;   assign cb[2] = if2.cnt_bad;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: running totals per instance (never cleared; the checks use deltas)
  int nb [3]     = '{0, 0, 0};
  int ndone [3]  = '{0, 0, 0};
  int nok [3]    = '{0, 0, 0};
  int nsof [3]   = '{0, 0, 0};
  int sofbad [3] = '{0, 0, 0};
  int viol [3]   = '{0, 0, 0};
  int sof_cyc [3] = '{0, 0, 0};
  int sof_idx0 = -1;
  logic [7:0] cap0 [$];
  logic [2:0] dv_prev = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ms[i]) begin
        nsof[i]++;
        sof_cyc[i] = cyc;
        if (!mv[i]) sofbad[i]++;
      end
      if (mv[i]) begin
        if (i == 0) begin
          if (ms[0]) sof_idx0 = cap0.size();
          cap0.push_back(if0.m_data);
        end
        if (!dv_prev[i]) viol[i]++;
        nb[i]++;
      end
      if (dn[i]) begin
        ndone[i]++;
        if (okv[i]) nok[i]++;
      end
    end
    dv_prev = rx_dv;
  end

  int checks = 0;
  int errors = 0;
  int exp_good [3] = '{0, 0, 0};
  int exp_bad [3]  = '{0, 0, 0};
  int t5 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         dut;
    int         pre_n;
    bit         has_sfd;
    logic [7:0] sfd;
    int         kind;       // 0: "123456789"+FCS, 1: pattern bytes with model FCS
    int         len;        // bytes DA..FCS
    bit         corrupt;    // flip bit 0 of the last byte
    int         er_at;      // body byte index with rx_er, -1 none
    int         exp_nb;
    int         exp_done;
    logic [2:0] exp_status;
    int         exp_len;    // -1: not checked
  } vec_t;

  function automatic vec_t mk(int dut, int pre_n, bit has_sfd, logic [7:0] sfd, int kind, int len,
                              bit corrupt, int er_at, int exp_nb, int exp_done,
                              logic [2:0] exp_status, int exp_len);
    vec_t v;
    v.dut = dut; v.pre_n = pre_n; v.has_sfd = has_sfd; v.sfd = sfd; v.kind = kind; v.len = len;
    v.corrupt = corrupt; v.er_at = er_at; v.exp_nb = exp_nb; v.exp_done = exp_done;
    v.exp_status = exp_status; v.exp_len = exp_len;
    return v;
  endfunction

  // Reference FCS: complemented reflected CRC-32 over the bytes.
  function automatic logic [31:0] fcs_of(input logic [7:0] q [$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive(input int d, input logic dv, input logic er, input logic [7:0] dat);
    rx_dv[d]   = dv;
    rx_er[d]   = er;
    rx_data[d] = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input int gap);
    logic [7:0]  fb [$];
    logic [31:0] c;
    fb = {};
    if (v.kind == 0) begin
      fb = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    end else if (v.len >= 4) begin
      for (int i = 0; i < v.len - 4; i++) fb.push_back(8'((i * 7 + 3) % 256));
      c = fcs_of(fb);
      fb.push_back(c[7:0]);
      fb.push_back(c[15:8]);
      fb.push_back(c[23:16]);
      fb.push_back(c[31:24]);
    end else begin
      for (int i = 0; i < v.len; i++) fb.push_back(8'((i * 7 + 3) % 256));
    end
    if (v.corrupt) fb[fb.size() - 1] = fb[fb.size() - 1] ^ 8'h01;
    for (int i = 0; i < v.pre_n; i++) drive(v.dut, 1'b1, 1'b0, 8'h55);
    if (v.has_sfd) drive(v.dut, 1'b1, 1'b0, v.sfd);
    for (int i = 0; i < fb.size(); i++) begin
      if (i == 4) t5 = cyc;
      drive(v.dut, 1'b1, (i == v.er_at), fb[i]);
    end
    for (int i = 0; i < gap; i++) drive(v.dut, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d, b_nb, b_done, b_ok, b_sof, b_sb, b_viol, b_cap;
    d = v.dut;
    b_nb = nb[d]; b_done = ndone[d]; b_ok = nok[d]; b_sof = nsof[d];
    b_sb = sofbad[d]; b_viol = viol[d]; b_cap = cap0.size();
    send(v, 6);
    if (v.exp_done != 0) begin
      if (v.exp_status == 3'd0) exp_good[d]++;
      else if (v.exp_status != 3'd5) exp_bad[d]++;
    end
    check({tag, " nbytes"}, nb[d] - b_nb, v.exp_nb);
    check({tag, " done_pulses"}, ndone[d] - b_done, v.exp_done);
    check({tag, " ok_pulses"}, nok[d] - b_ok, (v.exp_done != 0 && v.exp_status == 3'd0) ? 1 : 0);
    check({tag, " sof_pulses"}, nsof[d] - b_sof, (v.exp_nb > 0) ? 1 : 0);
    check({tag, " sof_without_valid"}, sofbad[d] - b_sb, 0);
    check({tag, " valid_after_dv_low"}, viol[d] - b_viol, 0);
    if (v.exp_done != 0) check({tag, " status"}, st[d], v.exp_status);
    if (v.exp_len >= 0) check({tag, " frame_len"}, fl[d], v.exp_len);
    check({tag, " cnt_good"}, cg[d], exp_good[d]);
    check({tag, " cnt_bad"}, cb[d], exp_bad[d]);
    if (d == 0 && v.kind == 0) begin
      for (int j = 0; j < 9; j++) begin
        if (b_cap + j < cap0.size()) check($sformatf("%s data%0d", tag, j), cap0[b_cap + j], 8'h31 + j);
        else check($sformatf("%s data%0d missing", tag, j), cap0.size(), b_cap + 9);
      end
      check({tag, " sof_index"}, sof_idx0, b_cap);
      check({tag, " first_byte_latency"}, sof_cyc[0], t5 + 1);
    end
  endtask

  vec_t vt [14];
  vec_t vg;
  int   b_done, b_ok, b_nb, b_sof;

  initial begin
    rst_n = 1'b0;
    rx_dv = '0;
    rx_er = '0;
    for (int i = 0; i < 3; i++) rx_data[i] = 8'h00;

    //          dut pre sfd? sfd   kind len cor er   nb  done st   len
    vt[0]  = mk(0,  7,  1,   8'hD5, 0,  13,  0, -1,   9, 1, 3'd0,  13);
    vt[1]  = mk(0,  7,  1,   8'hD5, 0,  13,  1, -1,   9, 1, 3'd1,  13);
    vt[2]  = mk(1,  7,  1,   8'hD5, 1,  60,  0, -1,  56, 1, 3'd2,  60);
    vt[3]  = mk(1,  7,  1,   8'hD5, 1,  60,  0, 10,  56, 1, 3'd4,  60);
    vt[4]  = mk(2,  7,  1,   8'hD5, 1, 120,  0, -1,  97, 1, 3'd3, 101);
    vt[5]  = mk(1,  2,  1,   8'hA0, 1,  10,  0, -1,   0, 1, 3'd5,  -1);
    vt[6]  = mk(1,  2,  0,   8'h00, 1,   0,  0, -1,   0, 0, 3'd0,  -1);
    vt[7]  = mk(1,  1,  1,   8'hD5, 1,  64,  0, -1,  60, 1, 3'd0,  64);
    vt[8]  = mk(1,  7,  1,   8'hD5, 1,   3,  0, -1,   0, 1, 3'd2,   3);
    vt[9]  = mk(1,  7,  1,   8'hD5, 1,  63,  0, -1,  59, 1, 3'd2,  63);
    vt[10] = mk(2,  7,  1,   8'hD5, 1, 100,  0, -1,  96, 1, 3'd0, 100);
    vt[11] = mk(2,  7,  1,   8'hD5, 1, 101,  0, -1,  97, 1, 3'd3, 101);
    vt[12] = mk(0,  7,  1,   8'hD5, 1,  64,  1, -1,  60, 1, 3'd1,  64);
    vt[13] = mk(1,  7,  1,   8'hD5, 1,  64,  0, 63,  60, 1, 3'd4,  64);

    repeat (3) @(posedge clk);
    #1;
    check("reset m_valid", if1.m_valid, 0);
    check("reset done", if1.done, 0);
    check("reset ok", if1.ok, 0);
    check("reset status", if1.status, 0);
    check("reset frame_len", if1.frame_len, 0);
    check("reset cnt_good", if1.cnt_good, 0);
    check("reset cnt_bad", if1.cnt_bad, 0);
    rst_n = 1'b1;
    repeat (2) drive(0, 1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 14; k++) run_vec(vt[k], $sformatf("v%0d", k));

    // back-to-back good frames, one idle cycle between them
    vg = mk(1, 7, 1, 8'hD5, 1, 64, 0, -1, 60, 1, 3'd0, 64);
    b_done = ndone[1]; b_ok = nok[1]; b_nb = nb[1]; b_sof = nsof[1];
    send(vg, 1);
    send(vg, 6);
    exp_good[1] += 2;
    check("b2b done_pulses", ndone[1] - b_done, 2);
    check("b2b ok_pulses", nok[1] - b_ok, 2);
    check("b2b nbytes", nb[1] - b_nb, 120);
    check("b2b sof_pulses", nsof[1] - b_sof, 2);
    check("b2b cnt_good", cg[1], exp_good[1]);

    // reset in the middle of a frame body
    b_done = ndone[1];
    for (int i = 0; i < 7; i++) drive(1, 1'b1, 1'b0, 8'h55);
    drive(1, 1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) drive(1, 1'b1, 1'b0, 8'(i + 16));
    rst_n = 1'b0;
    #1;
    check("midrst m_valid", if1.m_valid, 0);
    check("midrst done", if1.done, 0);
    check("midrst status", if1.status, 0);
    check("midrst frame_len", if1.frame_len, 0);
    check("midrst cnt_good", if1.cnt_good, 0);
    check("midrst cnt_bad", if1.cnt_bad, 0);
    drive(1, 1'b1, 1'b0, 8'h40);
    drive(1, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_good[i] = 0;
      exp_bad[i]  = 0;
    end
    repeat (4) drive(1, 1'b0, 1'b0, 8'h00);
    check("midrst no_done", ndone[1] - b_done, 0);
    run_vec(vg, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
